// File: rtl/lane_spawn_scheduler.sv
// Round-robin spawn scheduler: once per game tick, grants each requesting lane
// in turn, decides car/log spawn from the shared random word, applies a
// per-lane cooldown, and requests a generator reset on all-ones lock-up.
//
// state | meaning
// IDLE  | waiting for tick; grant/busy low; lock-up detection active
// SERVE | a grant is on the outputs; next pending lane is chosen each cycle
module lane_spawn_scheduler #(
  parameter int LANES     = 8,
  parameter int WIDTH     = 16,
  parameter int DENS_BITS = 4,
  parameter int COOLDOWN  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [LANES-1:0]         req,
  input  logic [WIDTH-1:0]         rand_in,
  input  logic [DENS_BITS-1:0]     density,
  output logic [LANES-1:0]         grant,
  output logic [$clog2(LANES)-1:0] lane_idx,
  output logic                     spawn,
  output logic                     busy,
  output logic                     tick_missed,
  output logic                     lfsr_reset
);

  localparam int IW = $clog2(LANES);
  localparam int CW = 4;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state, state_next;
  logic [LANES-1:0]  pending;
  logic [LANES-1:0]  cand;
  logic [LANES-1:0]  cool_zero;
  logic [LANES-1:0]  sel_onehot;
  logic [CW-1:0]     cool [LANES];
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     rr_next;
  logic              sel_valid;
  logic              spawn_next;
  logic              all_ones;
  logic              lock_seen;

  // Lanes whose cooldown has expired
  always_comb begin
    cool_zero = '0;
    for (int i = 0; i < LANES; i++) cool_zero[i] = (cool[i] == '0);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: stay in SERVE as long as something is left to grant this cycle
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = sel_valid ? SERVE : IDLE;
      SERVE:   state_next = sel_valid ? SERVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output comb: candidate set, round-robin pick and spawn decision for this cycle.
  // In IDLE the tick snapshot is picked from directly so the first grant lands
  // on the cycle right after the tick.
  always_comb begin
    int j;
    j          = 0;
    cand       = (state == SERVE) ? pending : (tick ? (req & cool_zero) : '0);
    sel_valid  = 1'b0;
    sel_idx    = '0;
    for (int k = 0; k < LANES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= LANES) j = j - LANES;
      if (!sel_valid && cand[IW'(j)]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(j);
      end
    end
    sel_onehot = sel_valid ? (LANES'(1) << sel_idx) : '0;
    spawn_next = sel_valid && (rand_in[DENS_BITS-1:0] < density);
    rr_next    = (sel_idx == IW'(LANES - 1)) ? '0 : sel_idx + 1'b1;
    all_ones   = &rand_in;
  end

  // Registered outputs, pending set, pointer, cooldowns and lock-up tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      lane_idx    <= '0;
      spawn       <= 1'b0;
      busy        <= 1'b0;
      tick_missed <= 1'b0;
      lfsr_reset  <= 1'b0;
      lock_seen   <= 1'b0;
      rr_ptr      <= '0;
      pending     <= '0;
      for (int i = 0; i < LANES; i++) cool[i] <= '0;
    end else begin
      grant       <= sel_onehot;
      lane_idx    <= sel_valid ? sel_idx : '0;
      spawn       <= spawn_next;
      busy        <= sel_valid;
      pending     <= cand & ~sel_onehot;
      tick_missed <= tick_missed | (tick && (state == SERVE));
      if (sel_valid) rr_ptr <= rr_next;
      // One pulse per lock-up episode; re-armed once a non-all-ones word is seen
      lfsr_reset  <= (state == IDLE) && all_ones && !lock_seen;
      lock_seen   <= all_ones && (lock_seen || (state == IDLE));
      for (int i = 0; i < LANES; i++) begin
        if (spawn_next && (sel_idx == IW'(i)))
          cool[i] <= CW'(COOLDOWN);
        else if ((state == IDLE) && tick && !cool_zero[i])
          cool[i] <= cool[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// Directed bench for lane_spawn_scheduler (LANES=8, WIDTH=16, DENS_BITS=4, COOLDOWN=3).
module tb_lane_spawn_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [7:0]  req;
  logic [15:0] rand_in;
  logic [3:0]  density;
  logic [7:0]  grant;
  logic [2:0]  lane_idx;
  logic        spawn;
  logic        busy;
  logic        tick_missed;
  logic        lfsr_reset;

  int vectors = 0;
  int errors  = 0;

  lane_spawn_scheduler #(.LANES(8), .WIDTH(16), .DENS_BITS(4), .COOLDOWN(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .req         (req),
    .rand_in     (rand_in),
    .density     (density),
    .grant       (grant),
    .lane_idx    (lane_idx),
    .spawn       (spawn),
    .busy        (busy),
    .tick_missed (tick_missed),
    .lfsr_reset  (lfsr_reset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [7:0] g, input logic [2:0] idx,
                             input logic sp);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".idx"},   32'(lane_idx), 32'(idx));
    check({tag, ".busy"},  32'(busy), 32'd1);
    check({tag, ".spawn"}, 32'(spawn), 32'(sp));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
  endtask

  // Single tick, single lane; returns to IDLE after the grant
  task automatic one_lane(input string tag, input logic [7:0] r, input logic [3:0] d,
                          input logic [15:0] rnd, input logic [2:0] idx, input logic sp);
    req = r; density = d; rand_in = rnd; tick = 1'b1;
    step();
    tick = 1'b0;
    check_grant(tag, 8'(1) << idx, idx, sp);
    step();
    check_idle({tag, ".end"});
  endtask

  logic [7:0] ovr_exp [8];

  initial begin
    reset = 1'b0; tick = 1'b0; req = 8'h00; rand_in = 16'h1230; density = 4'd0;

    // Reset hold
    repeat (3) step();
    check_idle("rst");
    check("rst.idx", 32'(lane_idx), 32'd0);
    check("rst.missed", 32'(tick_missed), 32'd0);
    check("rst.lfsr", 32'(lfsr_reset), 32'd0);
    reset = 1'b1; req = 8'hFF;
    step(); step();
    check_idle("post_rst");
    check("post_rst.spawn", 32'(spawn), 32'd0);

    // Round robin 0x85 from rr_ptr 0; req changes during SERVE are ignored
    req = 8'h85; tick = 1'b1;
    step();
    tick = 1'b0; req = 8'h00;
    check_grant("rr1a", 8'h01, 3'd0, 1'b0);
    step(); check_grant("rr1b", 8'h04, 3'd2, 1'b0);
    step(); check_grant("rr1c", 8'h80, 3'd7, 1'b0);
    step(); check_idle("rr1d");
    req = 8'h05; tick = 1'b1;
    step();
    tick = 1'b0;
    check_grant("rr2a", 8'h01, 3'd0, 1'b0);
    step(); check_grant("rr2b", 8'h04, 3'd2, 1'b0);
    step(); check_idle("rr2c");

    // Density edges (rr_ptr now 3)
    one_lane("dens0",     8'h08, 4'd0,  16'h1230, 3'd3, 1'b0);
    one_lane("dens15_0",  8'h10, 4'd15, 16'h1230, 3'd4, 1'b1);
    one_lane("dens15_15", 8'h20, 4'd15, 16'h000F, 3'd5, 1'b0);
    one_lane("dens8_7",   8'h40, 4'd8,  16'h0007, 3'd6, 1'b1);
    one_lane("dens8_8",   8'h01, 4'd8,  16'h0008, 3'd0, 1'b0);

    // Reset mid-serve: lane 6 still cooling (2) so snapshot is 0xBF, rr_ptr 1
    req = 8'hFF; density = 4'd0; rand_in = 16'h1230; tick = 1'b1;
    step();
    tick = 1'b0;
    check_grant("mid_rst_pre", 8'h02, 3'd1, 1'b0);
    reset = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst.idx", 32'(lane_idx), 32'd0);
    reset = 1'b1;
    step();
    check_idle("mid_rst_rel");
    // Lane 6 cooldown was cleared by the reset, so it is granted immediately
    one_lane("cool_clr", 8'h40, 4'd0, 16'h1230, 3'd6, 1'b0);

    // Cooldown: lane 2 spawns on tick 1, blocked ticks 2..4, back on tick 5
    one_lane("cd_t1", 8'h04, 4'd15, 16'h1230, 3'd2, 1'b1);
    one_lane("cd_t2", 8'h0C, 4'd0,  16'h1230, 3'd3, 1'b0);
    one_lane("cd_t3", 8'h0C, 4'd0,  16'h1230, 3'd3, 1'b0);
    one_lane("cd_t4", 8'h0C, 4'd0,  16'h1230, 3'd3, 1'b0);
    req = 8'h0C; tick = 1'b1;
    step();
    tick = 1'b0;
    check_grant("cd_t5a", 8'h04, 3'd2, 1'b0);
    step(); check_grant("cd_t5b", 8'h08, 3'd3, 1'b0);
    step(); check_idle("cd_t5c");

    // Overrun: all lanes from rr_ptr 4, second tick during the third grant
    ovr_exp[0] = 8'h10; ovr_exp[1] = 8'h20; ovr_exp[2] = 8'h40; ovr_exp[3] = 8'h80;
    ovr_exp[4] = 8'h01; ovr_exp[5] = 8'h02; ovr_exp[6] = 8'h04; ovr_exp[7] = 8'h08;
    req = 8'hFF; tick = 1'b1;
    step();
    for (int n = 0; n < 8; n++) begin
      check("ovr.grant", 32'(grant), 32'(ovr_exp[n]));
      check("ovr.missed", 32'(tick_missed), (n >= 3) ? 32'd1 : 32'd0);
      tick = (n == 2);
      step();
    end
    tick = 1'b0;
    check_idle("ovr_end");
    check("ovr_end.missed", 32'(tick_missed), 32'd1);

    // Lock-up recovery in IDLE
    req = 8'h00; rand_in = 16'hFFFF;
    step(); check("lk1", 32'(lfsr_reset), 32'd1);
    step(); check("lk2", 32'(lfsr_reset), 32'd0);
    step(); check("lk3", 32'(lfsr_reset), 32'd0);
    step(); check("lk4", 32'(lfsr_reset), 32'd0);
    rand_in = 16'h1234;
    step(); check("lk_rearm", 32'(lfsr_reset), 32'd0);
    rand_in = 16'hFFFF;
    step(); check("lk_again", 32'(lfsr_reset), 32'd1);
    step(); check("lk_again2", 32'(lfsr_reset), 32'd0);
    rand_in = 16'h1234;
    step(); check("lk_rearm2", 32'(lfsr_reset), 32'd0);

    // All-ones during SERVE: no pulse (rr_ptr 4 -> lanes 0 then 1)
    req = 8'h03; tick = 1'b1;
    step();
    tick = 1'b0; rand_in = 16'hFFFF;
    check_grant("lk_srv_a", 8'h01, 3'd0, 1'b0);
    step();
    rand_in = 16'h1234;
    check_grant("lk_srv_b", 8'h02, 3'd1, 1'b0);
    check("lk_srv_b.lfsr", 32'(lfsr_reset), 32'd0);
    step();
    check_idle("lk_srv_end");
    check("lk_srv_end.lfsr", 32'(lfsr_reset), 32'd0);

    // Tick together with lock-up in IDLE: both pulse and grant (rr_ptr 2)
    req = 8'h01; rand_in = 16'hFFFF; tick = 1'b1;
    step();
    tick = 1'b0; rand_in = 16'h1234;
    check_grant("lk_tick", 8'h01, 3'd0, 1'b0);
    check("lk_tick.lfsr", 32'(lfsr_reset), 32'd1);
    step();
    check_idle("lk_tick_end");
    check("lk_tick_end.lfsr", 32'(lfsr_reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
